// File: rtl/global_types.sv
// Shared execute-stage types: ALU control and multiply/divide opcodes.
package global_types;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_AND  = 4'd2,
    ALU_OR   = 4'd3,
    ALU_XOR  = 4'd4,
    ALU_NOR  = 4'd5,
    ALU_SLT  = 4'd6,
    ALU_SLTU = 4'd7,
    ALU_SLL  = 4'd8,
    ALU_SRL  = 4'd9,
    ALU_SRA  = 4'd10,
    ALU_LUI  = 4'd11
  } alu_ctrl_t;

  typedef enum logic [2:0] {
    MD_NONE  = 3'd0,
    MD_MULT  = 3'd1,
    MD_MULTU = 3'd2,
    MD_DIV   = 3'd3,
    MD_DIVU  = 3'd4,
    MD_MTHI  = 3'd5,
    MD_MTLO  = 3'd6
  } muldiv_op_t;

  // Quotient returned on divide-by-zero; sliced to the unit's width.
  localparam logic [63:0] MULDIV_DIV0_LO = {64{1'b1}};

  function automatic logic is_iterative_op(input logic [2:0] op);
    is_iterative_op = (op == MD_MULT) || (op == MD_MULTU) ||
                      (op == MD_DIV)  || (op == MD_DIVU);
  endfunction

endpackage

// File: rtl/execute_muldiv_step.sv
// One iteration of the shift-add multiplier or restoring divider.
module execute_muldiv_step
  import global_types::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [2*WIDTH-1:0] acc,
  input  logic [WIDTH-1:0]   operand,
  input  logic               mode,
  output logic [2*WIDTH-1:0] acc_next,
  output logic               q_bit
);

  logic [WIDTH:0]   sum_s;
  logic [WIDTH:0]   rem_sh_s;
  logic [WIDTH-1:0] diff_s;

  // Multiply: {partial, multiplier} shifts right; divide: {rem, dividend} shifts left, LSB left for q_bit.
  always_comb begin
    sum_s    = {1'b0, acc[2*WIDTH-1:WIDTH]} +
               (acc[0] ? {1'b0, operand} : {(WIDTH+1){1'b0}});
    rem_sh_s = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
    diff_s   = rem_sh_s[WIDTH-1:0] - operand;
    acc_next = {2*WIDTH{1'b0}};
    q_bit    = 1'b0;
    if (mode) begin
      if (rem_sh_s >= {1'b0, operand}) begin
        acc_next = {diff_s, acc[WIDTH-2:0], 1'b0};
        q_bit    = 1'b1;
      end else begin
        acc_next = {rem_sh_s[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
        q_bit    = 1'b0;
      end
    end else begin
      acc_next = {sum_s, acc[WIDTH-1:1]};
      q_bit    = 1'b0;
    end
  end

endmodule

// File: rtl/execute_muldiv.sv
// Iterative MULT/MULTU/DIV/DIVU unit owning HI/LO; stalls the pipeline while busy.
module execute_muldiv
  import global_types::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             flush,
  output logic             stall,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FIN  = 2'd2
  } state_t;

  state_t             state_r;
  logic [CW-1:0]      count_r;
  logic [2*WIDTH-1:0] acc_r;
  logic [WIDTH-1:0]   opnd_r;
  logic               is_div_r;
  logic               neg_res_r;
  logic               neg_rem_r;
  logic               div0_r;
  logic               busy_r;
  logic               done_r;
  logic [WIDTH-1:0]   hi_r;
  logic [WIDTH-1:0]   lo_r;

  logic               issue_s;
  logic               signed_op_s;
  logic               div_op_s;
  logic [WIDTH-1:0]   a_mag_s;
  logic [WIDTH-1:0]   b_mag_s;
  logic [2*WIDTH-1:0] step_acc_s;
  logic               step_q_s;
  logic [2*WIDTH-1:0] prod_s;
  logic [WIDTH-1:0]   fin_hi_s;
  logic [WIDTH-1:0]   fin_lo_s;

  function automatic logic [WIDTH-1:0] neg_w(input logic [WIDTH-1:0] v);
    neg_w = ~v + WIDTH'(1);
  endfunction

  function automatic logic [WIDTH-1:0] mag_w(input logic [WIDTH-1:0] v);
    if (v[WIDTH-1]) mag_w = neg_w(v);
    else            mag_w = v;
  endfunction

  execute_muldiv_step #(.WIDTH(WIDTH)) u_step (
    .acc      (acc_r),
    .operand  (opnd_r),
    .mode     (is_div_r),
    .acc_next (step_acc_s),
    .q_bit    (step_q_s)
  );

  // Issue decode and operand magnitudes (signed ops run on |a|, |b|).
  always_comb begin
    issue_s     = start & ~flush & is_iterative_op(op);
    signed_op_s = (op == MD_MULT) || (op == MD_DIV);
    div_op_s    = (op == MD_DIV)  || (op == MD_DIVU);
    if (signed_op_s) begin
      a_mag_s = mag_w(a);
      b_mag_s = mag_w(b);
    end else begin
      a_mag_s = a;
      b_mag_s = b;
    end
  end

  // Sign correction of the finished unsigned result.
  always_comb begin
    prod_s   = {2*WIDTH{1'b0}};
    fin_hi_s = {WIDTH{1'b0}};
    fin_lo_s = {WIDTH{1'b0}};
    if (is_div_r) begin
      fin_hi_s = neg_rem_r ? neg_w(acc_r[2*WIDTH-1:WIDTH]) : acc_r[2*WIDTH-1:WIDTH];
      if (div0_r) fin_lo_s = MULDIV_DIV0_LO[WIDTH-1:0];
      else        fin_lo_s = neg_res_r ? neg_w(acc_r[WIDTH-1:0]) : acc_r[WIDTH-1:0];
    end else begin
      prod_s = neg_res_r ? (~acc_r + (2*WIDTH)'(1)) : acc_r;
      {fin_hi_s, fin_lo_s} = prod_s;
    end
  end

  // Control FSM, iteration datapath and HI/LO registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_r   <= ST_IDLE;
      count_r   <= {CW{1'b0}};
      acc_r     <= {2*WIDTH{1'b0}};
      opnd_r    <= {WIDTH{1'b0}};
      is_div_r  <= 1'b0;
      neg_res_r <= 1'b0;
      neg_rem_r <= 1'b0;
      div0_r    <= 1'b0;
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
      hi_r      <= {WIDTH{1'b0}};
      lo_r      <= {WIDTH{1'b0}};
    end else begin
      done_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (issue_s) begin
            acc_r     <= div_op_s ? {{WIDTH{1'b0}}, a_mag_s} : {{WIDTH{1'b0}}, b_mag_s};
            opnd_r    <= div_op_s ? b_mag_s : a_mag_s;
            is_div_r  <= div_op_s;
            neg_res_r <= signed_op_s & (a[WIDTH-1] ^ b[WIDTH-1]);
            neg_rem_r <= signed_op_s & a[WIDTH-1];
            div0_r    <= (b == {WIDTH{1'b0}});
            count_r   <= {CW{1'b0}};
            busy_r    <= 1'b1;
            state_r   <= ST_RUN;
          end else if (start && !flush && op == MD_MTHI) begin
            hi_r <= a;
          end else if (start && !flush && op == MD_MTLO) begin
            lo_r <= a;
          end
        end
        ST_RUN: begin
          if (flush) begin
            busy_r  <= 1'b0;
            state_r <= ST_IDLE;
          end else begin
            acc_r   <= step_acc_s | {{(2*WIDTH-1){1'b0}}, step_q_s};
            count_r <= count_r + CW'(1);
            if (count_r == CW'(WIDTH-1)) state_r <= ST_FIN;
          end
        end
        ST_FIN: begin
          if (!flush) begin
            hi_r   <= fin_hi_s;
            lo_r   <= fin_lo_s;
            done_r <= 1'b1;
          end
          busy_r  <= 1'b0;
          state_r <= ST_IDLE;
        end
        default: begin
          busy_r  <= 1'b0;
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  assign stall = busy_r | issue_s;
  assign busy  = busy_r;
  assign done  = done_r;
  assign hi    = hi_r;
  assign lo    = lo_r;

endmodule

// File: tb/tb_execute_muldiv.sv
// Directed bench for execute_muldiv with a cycle-level reference model and per-cycle compare.
module tb_execute_muldiv;
  import global_types::*;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [2:0]  op    = MD_NONE;
  logic [31:0] a     = 32'd0;
  logic [31:0] b     = 32'd0;
  logic        flush = 1'b0;
  logic        stall, busy, done;
  logic [31:0] hi, lo;

  int checks = 0;
  int errors = 0;

  execute_muldiv #(.WIDTH(32)) dut (
    .clock (clock), .reset (reset), .start (start), .op (op),
    .a (a), .b (b), .flush (flush),
    .stall (stall), .busy (busy), .done (done), .hi (hi), .lo (lo)
  );

  always #5 clock = ~clock;

  // Reference: the architectural result of each op, straight from integer arithmetic.
  function automatic logic [63:0] ref_result(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
    longint sx, sy, q, r;
    logic [63:0] res;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    res = 64'd0;
    case (o)
      MD_MULT:  res = 64'(sx * sy);
      MD_MULTU: res = {32'd0, x} * {32'd0, y};
      MD_DIV: begin
        if (y == 32'd0) res = {x, 32'hFFFFFFFF};
        else begin
          q = sx / sy;
          r = sx % sy;
          res = {32'(r), 32'(q)};
        end
      end
      MD_DIVU: begin
        if (y == 32'd0) res = {x, 32'hFFFFFFFF};
        else res = {x % y, x / y};
      end
      default: res = 64'd0;
    endcase
    return res;
  endfunction

  logic [31:0] m_hi = 32'd0, m_lo = 32'd0, p_hi = 32'd0, p_lo = 32'd0;
  logic        m_busy = 1'b0, m_done = 1'b0;
  int          m_left = 0;

  // Model: a result lands 33 edges after issue unless flushed first.
  always @(posedge clock or posedge reset) begin
    if (reset) begin
      m_hi <= 32'd0; m_lo <= 32'd0; m_busy <= 1'b0; m_done <= 1'b0; m_left <= 0;
    end else begin
      m_done <= 1'b0;
      if (m_busy) begin
        if (flush) m_busy <= 1'b0;
        else if (m_left == 1) begin
          m_hi <= p_hi; m_lo <= p_lo; m_done <= 1'b1; m_busy <= 1'b0;
        end else m_left <= m_left - 1;
      end else if (start && !flush) begin
        if (op inside {MD_MULT, MD_MULTU, MD_DIV, MD_DIVU}) begin
          {p_hi, p_lo} <= ref_result(op, a, b);
          m_left <= 33;
          m_busy <= 1'b1;
        end else if (op == MD_MTHI) m_hi <= a;
        else if (op == MD_MTLO) m_lo <= a;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %08h expected %08h", name, $time, act, exp);
    end
  endtask

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clock) begin
    chk("hi", hi, m_hi);
    chk("lo", lo, m_lo);
    chk("busy", {31'd0, busy}, {31'd0, m_busy});
    chk("done", {31'd0, done}, {31'd0, m_done});
    chk("stall", {31'd0, stall},
        {31'd0, m_busy | (start & ~flush & (op inside {MD_MULT, MD_MULTU, MD_DIV, MD_DIVU}))});
  end

  // Called at posedge+2; drives one issue cycle.
  task automatic issue(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y, input logic fl);
    start = 1'b1; op = o; a = x; b = y; flush = fl;
    @(posedge clock); #2;
    start = 1'b0; op = MD_NONE; flush = 1'b0;
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (done !== 1'b1 && n < 40) begin
      @(posedge clock); #2;
      n++;
    end
    checks++;
    if (done !== 1'b1) begin
      errors++;
      $display("FAIL wait_done timeout: done=%b expected 1", done);
    end
  endtask

  task automatic run_op(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                        input logic [31:0] ehi, input logic [31:0] elo, input string name);
    issue(o, x, y, 1'b0);
    wait_done();
    chk({name, "_hi"}, hi, ehi);
    chk({name, "_lo"}, lo, elo);
  endtask

  initial begin
    #1;
    chk("rst_hi", hi, 32'd0);
    chk("rst_lo", lo, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    @(posedge clock); @(posedge clock); #2;
    reset = 1'b0;
    @(posedge clock); #2;

    run_op(MD_MULT,  32'd7,        32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFEB, "mult_7_m3");
    run_op(MD_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, "multu_max");
    run_op(MD_DIVU,  32'd100,      32'd7,        32'd2,        32'd14,       "divu_100_7");
    run_op(MD_DIV,   32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, "div_m7_2");
    run_op(MD_DIV,   32'h80000000, 32'hFFFFFFFF, 32'd0,        32'h80000000, "div_ovf");
    run_op(MD_DIV,   32'd7,        32'hFFFFFFFE, 32'd1,        32'hFFFFFFFD, "div_7_m2");
    run_op(MD_MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'd0,        "mult_min");
    run_op(MD_DIVU,  32'd9,        32'd0,        32'd9,        32'hFFFFFFFF, "divu_by0");
    run_op(MD_DIV,   32'hFFFFFFFB, 32'd0,        32'hFFFFFFFB, 32'hFFFFFFFF, "div_m5_by0");
    run_op(MD_DIV,   32'd5,        32'd0,        32'd5,        32'hFFFFFFFF, "div_5_by0");

    // Flush during RUN: no done, HI/LO keep the previous result.
    issue(MD_MULT, 32'd3, 32'd4, 1'b0);
    repeat (8) begin @(posedge clock); #2; end
    flush = 1'b1;
    @(posedge clock); #2;
    flush = 1'b0;
    chk("flush_busy", {31'd0, busy}, 32'd0);
    repeat (40) begin @(posedge clock); #2; end
    chk("flush_hi", hi, 32'd5);
    chk("flush_lo", lo, 32'hFFFFFFFF);

    // MTHI, then MTLO squashed by flush, then start+flush for an arithmetic op.
    issue(MD_MTHI, 32'h12345678, 32'd0, 1'b0);
    chk("mthi_hi", hi, 32'h12345678);
    issue(MD_MTLO, 32'hDEADBEEF, 32'd0, 1'b1);
    chk("mtlo_flush_lo", lo, 32'hFFFFFFFF);
    issue(MD_DIVU, 32'd50, 32'd5, 1'b1);
    chk("startflush_busy", {31'd0, busy}, 32'd0);
    issue(MD_MTLO, 32'hCAFEF00D, 32'd0, 1'b0);
    chk("mtlo_lo", lo, 32'hCAFEF00D);

    // New op issued in the done cycle.
    issue(MD_DIVU, 32'd100, 32'd7, 1'b0);
    wait_done();
    run_op(MD_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, "b2b_multu");

    // Asynchronous reset mid-RUN clears HI/LO immediately.
    issue(MD_MULT, 32'd7, 32'hFFFFFFFD, 1'b0);
    repeat (5) begin @(posedge clock); #2; end
    reset = 1'b1;
    #1;
    chk("midrst_hi", hi, 32'd0);
    chk("midrst_lo", lo, 32'd0);
    chk("midrst_busy", {31'd0, busy}, 32'd0);
    @(posedge clock); #2;
    reset = 1'b0;
    repeat (3) begin @(posedge clock); #2; end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
